// File: rtl/dispatch_queue.sv
// In-order dispatch buffer between decoder and back end: holds decoded ops,
// routes the head to the RS or LSB, and snoops both result buses for operands.
module dispatch_queue #(
  parameter int DEPTH     = 4,
  parameter int ROB_IDX_W = 4,
  parameter int OPENUM_W  = 6
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 flush_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_is_mem,
  input  logic [OPENUM_W-1:0]  in_op,
  input  logic [31:0]          in_rs1_val,
  input  logic [31:0]          in_rs2_val,
  input  logic [ROB_IDX_W-1:0] in_rs1_dep,
  input  logic [ROB_IDX_W-1:0] in_rs2_dep,
  input  logic [4:0]           in_rd,
  input  logic [31:0]          in_imm,
  input  logic [31:0]          in_pc,
  input  logic [ROB_IDX_W-1:0] in_rob_idx,
  input  logic                 alu_result_ready,
  input  logic [ROB_IDX_W-1:0] alu_result_rob_index,
  input  logic [31:0]          alu_result_val,
  input  logic                 lsb_result_ready,
  input  logic [ROB_IDX_W-1:0] lsb_result_rob_index,
  input  logic [31:0]          lsb_result_val,
  input  logic                 rs_full,
  input  logic                 lsb_full,
  output logic                 rs_issue_valid,
  output logic                 lsb_issue_valid,
  output logic [OPENUM_W-1:0]  out_op,
  output logic [31:0]          out_rs1_val,
  output logic [ROB_IDX_W-1:0] out_rs1_dep,
  output logic [31:0]          out_rs2_val,
  output logic [ROB_IDX_W-1:0] out_rs2_dep,
  output logic [4:0]           out_rd,
  output logic [31:0]          out_imm,
  output logic [31:0]          out_pc,
  output logic [ROB_IDX_W-1:0] out_rob_idx
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [31:0]          val;
    logic [ROB_IDX_W-1:0] dep;
  } operand_t;

  // Resolve a pending operand from the result buses; the ALU bus wins a tie.
  function automatic operand_t wake(input operand_t opnd);
    wake = opnd;
    if (opnd.dep != '0) begin
      if (alu_result_ready && alu_result_rob_index == opnd.dep) begin
        wake.val = alu_result_val;
        wake.dep = '0;
      end else if (lsb_result_ready && lsb_result_rob_index == opnd.dep) begin
        wake.val = lsb_result_val;
        wake.dep = '0;
      end
    end
  endfunction

  logic                 mem_is_mem [DEPTH];
  logic [OPENUM_W-1:0]  mem_op     [DEPTH];
  operand_t             mem_rs1    [DEPTH];
  operand_t             mem_rs2    [DEPTH];
  logic [4:0]           mem_rd     [DEPTH];
  logic [31:0]          mem_imm    [DEPTH];
  logic [31:0]          mem_pc     [DEPTH];
  logic [ROB_IDX_W-1:0] mem_rob    [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic     not_empty;
  logic     head_is_mem;
  logic     push;
  logic     pop;
  operand_t head_rs1;
  operand_t head_rs2;

  always_comb begin
    not_empty       = (count != '0);
    head_is_mem     = mem_is_mem[head];
    in_ready        = !rst_in && !flush_in && (count < FULL_CNT);
    push            = in_valid && in_ready && rdy_in;
    pop             = not_empty && rdy_in && !flush_in && !rst_in &&
                      (head_is_mem ? !lsb_full : !rs_full);
    rs_issue_valid  = pop && !head_is_mem;
    lsb_issue_valid = pop && head_is_mem;
    head_rs1        = wake(mem_rs1[head]);
    head_rs2        = wake(mem_rs2[head]);
  end

  // Payload is forced to zero when empty so stale slots never leak out.
  always_comb begin
    out_op      = '0;
    out_rs1_val = '0;
    out_rs1_dep = '0;
    out_rs2_val = '0;
    out_rs2_dep = '0;
    out_rd      = '0;
    out_imm     = '0;
    out_pc      = '0;
    out_rob_idx = '0;
    if (not_empty) begin
      out_op      = mem_op[head];
      out_rs1_val = head_rs1.val;
      out_rs1_dep = head_rs1.dep;
      out_rs2_val = head_rs2.val;
      out_rs2_dep = head_rs2.dep;
      out_rd      = mem_rd[head];
      out_imm     = mem_imm[head];
      out_pc      = mem_pc[head];
      out_rob_idx = mem_rob[head];
    end
  end

  // Free slots are snooped too; harmless, and keeps the update loop uniform.
  always_ff @(posedge clk_in) begin
    if (rst_in || flush_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_rs1[i] <= wake(mem_rs1[i]);
        mem_rs2[i] <= wake(mem_rs2[i]);
      end
      if (push) begin
        mem_is_mem[tail] <= in_is_mem;
        mem_op[tail]     <= in_op;
        mem_rs1[tail]    <= wake({in_rs1_val, in_rs1_dep});
        mem_rs2[tail]    <= wake({in_rs2_val, in_rs2_dep});
        mem_rd[tail]     <= in_rd;
        mem_imm[tail]    <= in_imm;
        mem_pc[tail]     <= in_pc;
        mem_rob[tail]    <= in_rob_idx;
        tail             <= tail + PTR_W'(1);
      end
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (!push && pop) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dispatch_queue.sv
// Bench for dispatch_queue: directed vector table, hand-written corner sequences
// and randomized traffic, all checked against a queue-based reference model.
module tb_dispatch_queue;

  localparam int DEPTH     = 4;
  localparam int ROB_IDX_W = 4;
  localparam int OPENUM_W  = 6;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic                 rst_in, rdy_in, flush_in, in_valid, in_ready, in_is_mem;
  logic [OPENUM_W-1:0]  in_op;
  logic [31:0]          in_rs1_val, in_rs2_val, in_imm, in_pc;
  logic [ROB_IDX_W-1:0] in_rs1_dep, in_rs2_dep, in_rob_idx;
  logic [4:0]           in_rd;
  logic                 alu_result_ready, lsb_result_ready;
  logic [ROB_IDX_W-1:0] alu_result_rob_index, lsb_result_rob_index;
  logic [31:0]          alu_result_val, lsb_result_val;
  logic                 rs_full, lsb_full, rs_issue_valid, lsb_issue_valid;
  logic [OPENUM_W-1:0]  out_op;
  logic [31:0]          out_rs1_val, out_rs2_val, out_imm, out_pc;
  logic [ROB_IDX_W-1:0] out_rs1_dep, out_rs2_dep, out_rob_idx;
  logic [4:0]           out_rd;

  dispatch_queue #(.DEPTH(DEPTH), .ROB_IDX_W(ROB_IDX_W), .OPENUM_W(OPENUM_W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_is_mem(in_is_mem), .in_op(in_op),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
    .in_rs1_dep(in_rs1_dep), .in_rs2_dep(in_rs2_dep),
    .in_rd(in_rd), .in_imm(in_imm), .in_pc(in_pc), .in_rob_idx(in_rob_idx),
    .alu_result_ready(alu_result_ready), .alu_result_rob_index(alu_result_rob_index),
    .alu_result_val(alu_result_val),
    .lsb_result_ready(lsb_result_ready), .lsb_result_rob_index(lsb_result_rob_index),
    .lsb_result_val(lsb_result_val),
    .rs_full(rs_full), .lsb_full(lsb_full),
    .rs_issue_valid(rs_issue_valid), .lsb_issue_valid(lsb_issue_valid),
    .out_op(out_op), .out_rs1_val(out_rs1_val), .out_rs1_dep(out_rs1_dep),
    .out_rs2_val(out_rs2_val), .out_rs2_dep(out_rs2_dep), .out_rd(out_rd),
    .out_imm(out_imm), .out_pc(out_pc), .out_rob_idx(out_rob_idx)
  );

  typedef struct {
    logic                 is_mem;
    logic [OPENUM_W-1:0]  op;
    logic [31:0]          v1;
    logic [ROB_IDX_W-1:0] d1;
    logic [31:0]          v2;
    logic [ROB_IDX_W-1:0] d2;
    logic [4:0]           rd;
    logic [31:0]          imm;
    logic [31:0]          pc;
    logic [ROB_IDX_W-1:0] rob;
  } entry_t;

  typedef struct {
    logic        valid;
    logic        is_mem;
    logic [31:0] pc;
    logic        rsf;
    logic        lsbf;
    logic        exp_ready;
    logic        exp_rs;
    logic        exp_lsb;
    logic [31:0] exp_pc;
  } vec_t;

  entry_t model_q[$];
  vec_t   vecs[17];
  int     errors = 0;
  int     checks = 0;

  function automatic entry_t mk(input logic is_mem, input logic [31:0] pc,
                                input logic [ROB_IDX_W-1:0] d1, input logic [ROB_IDX_W-1:0] d2);
    entry_t e;
    e.is_mem = is_mem;
    e.op     = OPENUM_W'($urandom);
    e.v1     = $urandom;
    e.d1     = d1;
    e.v2     = $urandom;
    e.d2     = d2;
    e.rd     = 5'($urandom);
    e.imm    = $urandom;
    e.pc     = pc;
    e.rob    = ROB_IDX_W'($urandom_range(1, 15));
    return e;
  endfunction

  // A producer broadcast resolves a waiting operand; ALU has priority.
  function automatic entry_t wake_entry(input entry_t e);
    entry_t r = e;
    if (r.d1 != 0) begin
      if (alu_result_ready && alu_result_rob_index == r.d1) begin r.v1 = alu_result_val; r.d1 = 0; end
      else if (lsb_result_ready && lsb_result_rob_index == r.d1) begin r.v1 = lsb_result_val; r.d1 = 0; end
    end
    if (r.d2 != 0) begin
      if (alu_result_ready && alu_result_rob_index == r.d2) begin r.v2 = alu_result_val; r.d2 = 0; end
      else if (lsb_result_ready && lsb_result_rob_index == r.d2) begin r.v2 = lsb_result_val; r.d2 = 0; end
    end
    return r;
  endfunction

  function automatic logic head_goes();
    if (model_q.size() == 0 || !rdy_in || flush_in || rst_in) return 1'b0;
    return model_q[0].is_mem ? !lsb_full : !rs_full;
  endfunction

  function automatic void check_eq(input string name, input logic [150:0] act, input logic [150:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic applyStimulus(input logic valid, input entry_t e, input logic rsf, input logic lsbf);
    in_valid   = valid;
    in_is_mem  = e.is_mem;
    in_op      = e.op;
    in_rs1_val = e.v1;
    in_rs1_dep = e.d1;
    in_rs2_val = e.v2;
    in_rs2_dep = e.d2;
    in_rd      = e.rd;
    in_imm     = e.imm;
    in_pc      = e.pc;
    in_rob_idx = e.rob;
    rs_full    = rsf;
    lsb_full   = lsbf;
  endtask

  task automatic checkOutput();
    logic go;
    logic head_mem;
    logic [150:0] exp_payload;
    entry_t h;
    go = head_goes();
    head_mem = (model_q.size() != 0) ? model_q[0].is_mem : 1'b0;
    exp_payload = '0;
    if (model_q.size() != 0) begin
      h = wake_entry(model_q[0]);
      exp_payload = {h.op, h.v1, h.d1, h.v2, h.d2, h.rd, h.imm, h.pc, h.rob};
    end
    check_eq("in_ready", in_ready, !rst_in && !flush_in && (model_q.size() < DEPTH));
    check_eq("rs_issue_valid", rs_issue_valid, go && !head_mem);
    check_eq("lsb_issue_valid", lsb_issue_valid, go && head_mem);
    check_eq("payload", {out_op, out_rs1_val, out_rs1_dep, out_rs2_val, out_rs2_dep,
                         out_rd, out_imm, out_pc, out_rob_idx}, exp_payload);
  endtask

  task automatic model_update();
    logic go;
    logic do_push;
    entry_t incoming;
    if (rst_in || flush_in) begin
      model_q.delete();
    end else if (rdy_in) begin
      go = head_goes();
      do_push = in_valid && (model_q.size() < DEPTH);
      incoming = '{in_is_mem, in_op, in_rs1_val, in_rs1_dep, in_rs2_val, in_rs2_dep,
                   in_rd, in_imm, in_pc, in_rob_idx};
      if (go) void'(model_q.pop_front());
      foreach (model_q[i]) model_q[i] = wake_entry(model_q[i]);
      if (do_push) model_q.push_back(wake_entry(incoming));
    end
  endtask

  task automatic cycle_begin();
    @(negedge clk_in);
    checkOutput();
  endtask

  task automatic cycle_end();
    @(posedge clk_in);
    model_update();
    #1;
  endtask

  task automatic cycle();
    cycle_begin();
    cycle_end();
  endtask

  task automatic bus_idle();
    alu_result_ready     = 1'b0;
    alu_result_rob_index = '0;
    alu_result_val       = '0;
    lsb_result_ready     = 1'b0;
    lsb_result_rob_index = '0;
    lsb_result_val       = '0;
  endtask

  initial begin
    entry_t e;
    rst_in   = 1'b1;
    rdy_in   = 1'b1;
    flush_in = 1'b0;
    bus_idle();
    applyStimulus(1'b0, mk(1'b0, 32'h0, 0, 0), 1'b0, 1'b0);

    // Reset: in_ready low while held, everything quiet afterwards.
    for (int i = 0; i < 2; i++) begin
      cycle_begin();
      check_eq("reset_in_ready", in_ready, 1'b0);
      cycle_end();
    end
    rst_in = 1'b0;
    cycle_begin();
    check_eq("post_reset_in_ready", in_ready, 1'b1);
    check_eq("post_reset_valids", {rs_issue_valid, lsb_issue_valid}, 2'b00);
    check_eq("post_reset_pc", out_pc, 32'h0);
    cycle_end();

    // Fill/drain and head-of-line block, one record per cycle.
    vecs[0]  = '{1'b1, 1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00};
    vecs[1]  = '{1'b1, 1'b0, 32'h04, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00};
    vecs[2]  = '{1'b1, 1'b0, 32'h08, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00};
    vecs[3]  = '{1'b1, 1'b0, 32'h0C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00};
    vecs[4]  = '{1'b1, 1'b0, 32'h10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00};
    vecs[5]  = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00};
    vecs[6]  = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h04};
    vecs[7]  = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h08};
    vecs[8]  = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0C};
    vecs[9]  = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00};
    vecs[10] = '{1'b1, 1'b1, 32'h20, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h00};
    vecs[11] = '{1'b1, 1'b0, 32'h24, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h20};
    vecs[12] = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h20};
    vecs[13] = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h20};
    vecs[14] = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h20};
    vecs[15] = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h24};
    vecs[16] = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00};
    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].valid, mk(vecs[i].is_mem, vecs[i].pc, 0, 0), vecs[i].rsf, vecs[i].lsbf);
      cycle_begin();
      check_eq($sformatf("tbl%0d_ready", i), in_ready, vecs[i].exp_ready);
      check_eq($sformatf("tbl%0d_valids", i), {rs_issue_valid, lsb_issue_valid},
               {vecs[i].exp_rs, vecs[i].exp_lsb});
      check_eq($sformatf("tbl%0d_pc", i), out_pc, vecs[i].exp_pc);
      cycle_end();
    end

    // Stored wakeup while the head is blocked.
    applyStimulus(1'b1, mk(1'b0, 32'h100, 4'd3, 4'd0), 1'b1, 1'b0);
    cycle();
    applyStimulus(1'b0, mk(1'b0, 32'h0, 0, 0), 1'b1, 1'b0);
    alu_result_ready = 1'b1; alu_result_rob_index = 4'd3; alu_result_val = 32'hDEADBEEF;
    cycle();
    bus_idle();
    rs_full = 1'b0;
    cycle_begin();
    check_eq("stored_wake_val", out_rs1_val, 32'hDEADBEEF);
    check_eq("stored_wake_dep", out_rs1_dep, 4'd0);
    check_eq("stored_wake_issue", rs_issue_valid, 1'b1);
    cycle_end();

    // Dispatch-cycle forward from the LSB bus.
    applyStimulus(1'b1, mk(1'b0, 32'h200, 4'd0, 4'd5), 1'b1, 1'b0);
    cycle();
    applyStimulus(1'b0, mk(1'b0, 32'h0, 0, 0), 1'b0, 1'b0);
    lsb_result_ready = 1'b1; lsb_result_rob_index = 4'd5; lsb_result_val = 32'h1234;
    cycle_begin();
    check_eq("fwd_rs2_val", out_rs2_val, 32'h1234);
    check_eq("fwd_rs2_dep", out_rs2_dep, 4'd0);
    check_eq("fwd_issue", rs_issue_valid, 1'b1);
    cycle_end();
    bus_idle();

    // Flush colliding with a push.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, mk(1'b0, 32'h300 + 32'(i * 4), 0, 0), 1'b1, 1'b0);
      cycle();
    end
    applyStimulus(1'b1, mk(1'b0, 32'h3F0, 0, 0), 1'b0, 1'b0);
    flush_in = 1'b1;
    cycle_begin();
    check_eq("flush_valids", {rs_issue_valid, lsb_issue_valid}, 2'b00);
    cycle_end();
    flush_in = 1'b0;
    applyStimulus(1'b0, mk(1'b0, 32'h0, 0, 0), 1'b0, 1'b0);
    cycle_begin();
    check_eq("after_flush_pc", out_pc, 32'h0);
    check_eq("after_flush_issue", rs_issue_valid, 1'b0);
    cycle_end();

    // Ten push/pop pairs so both pointers wrap.
    applyStimulus(1'b1, mk(1'b0, 32'h400, 0, 0), 1'b0, 1'b0);
    cycle();
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(1'b1, mk(1'b0, 32'h400 + 32'(4 * k), 0, 0), 1'b0, 1'b0);
      cycle_begin();
      check_eq("wrap_pc", out_pc, 32'h400 + 32'(4 * (k - 1)));
      cycle_end();
    end
    applyStimulus(1'b0, mk(1'b0, 32'h0, 0, 0), 1'b0, 1'b0);
    cycle_begin();
    check_eq("wrap_last_pc", out_pc, 32'h428);
    cycle_end();

    // Freeze with a pending ALU broadcast.
    applyStimulus(1'b1, mk(1'b0, 32'h500, 4'd7, 4'd0), 1'b1, 1'b0);
    cycle();
    applyStimulus(1'b1, mk(1'b1, 32'h504, 0, 0), 1'b1, 1'b0);
    cycle();
    rdy_in = 1'b0;
    applyStimulus(1'b1, mk(1'b0, 32'h508, 0, 0), 1'b0, 1'b0);
    alu_result_ready = 1'b1; alu_result_rob_index = 4'd7; alu_result_val = 32'hCAFEF00D;
    for (int i = 0; i < 2; i++) begin
      cycle_begin();
      check_eq("freeze_valids", {rs_issue_valid, lsb_issue_valid}, 2'b00);
      cycle_end();
    end
    rdy_in = 1'b1;
    bus_idle();
    applyStimulus(1'b0, mk(1'b0, 32'h0, 0, 0), 1'b0, 1'b0);
    cycle_begin();
    check_eq("freeze_dep_held", out_rs1_dep, 4'd7);
    check_eq("freeze_head_pc", out_pc, 32'h500);
    cycle_end();
    cycle_begin();
    check_eq("freeze_second", {lsb_issue_valid, out_pc}, {1'b1, 32'h504});
    cycle_end();

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      e = mk(1'($urandom), $urandom,
             ($urandom_range(0, 1) != 0) ? ROB_IDX_W'($urandom_range(1, 7)) : '0,
             ($urandom_range(0, 1) != 0) ? ROB_IDX_W'($urandom_range(1, 7)) : '0);
      applyStimulus($urandom_range(0, 3) != 0, e, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
      rst_in   = ($urandom_range(0, 63) == 0);
      flush_in = ($urandom_range(0, 31) == 0);
      rdy_in   = ($urandom_range(0, 7) != 0);
      alu_result_ready     = 1'($urandom);
      alu_result_rob_index = ROB_IDX_W'($urandom_range(0, 7));
      alu_result_val       = $urandom;
      lsb_result_ready     = 1'($urandom);
      lsb_result_rob_index = ROB_IDX_W'($urandom_range(0, 7));
      lsb_result_val       = $urandom;
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dispatch_queue.md
# dispatch_queue

In-order dispatch buffer between the decoder and the execution back end (ALU reservation station and load/store buffer). It accepts one decoded instruction per cycle and stores up to DEPTH entries. It routes the head entry to the RS or the LSB when that unit has room, and snoops both result buses so buffered operands never miss a broadcast. Mispredict flush clears it in one cycle.

## Interface
- DEPTH, 4, entry count; power of 2, ≥2
- ROB_IDX_W, 4, ROB index width; index 0 means "no dependency"
- OPENUM_W, 6, internal op-enum width
- clk_in  in  1  clock, all state on rising edge
- rst_in  in  1  reset, synchronous, active-high
- rdy_in  in  1  global enable; low freezes all state
- flush_in  in  1  mispredict flush, synchronous
- in_valid  in  1  decoder presents an instruction
- in_ready  out  1  queue accepts this cycle
- in_is_mem  in  1  1 = LSB op, 0 = RS op
- in_op  in  OPENUM_W  op enum
- in_rs1_val, in_rs2_val  in  32  operand values
- in_rs1_dep, in_rs2_dep  in  ROB_IDX_W  producer ROB index, 0 = value valid
- in_rd  in  5  destination register
- in_imm  in  32  immediate
- in_pc  in  32  instruction PC
- in_rob_idx  in  ROB_IDX_W  ROB slot of this instruction
- alu_result_ready / alu_result_rob_index / alu_result_val  in  1 / ROB_IDX_W / 32  ALU broadcast
- lsb_result_ready / lsb_result_rob_index / lsb_result_val  in  1 / ROB_IDX_W / 32  LSB broadcast
- rs_full, lsb_full  in  1  target cannot take an entry this cycle
- rs_issue_valid, lsb_issue_valid  out  1  head dispatched to RS / LSB this cycle
- out_op, out_rs1_val, out_rs1_dep, out_rs2_val, out_rs2_dep, out_rd, out_imm, out_pc, out_rob_idx  out  widths as inputs  shared head payload

## Operation
- **Storage.** Circular buffer with head/tail pointers of log2(DEPTH) bits and a count of log2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
- **Push.** Occurs when in_valid && in_ready && rdy_in && !flush_in. The entry is written at tail.
- **in_ready.** Equals !rst_in && !flush_in && count < DEPTH. A full queue does not accept a push even when a pop happens in the same cycle.
- **Head target.** The head entry targets the LSB if is_mem, otherwise the RS.
- **Dispatch (pop).** Occurs when count>0, rdy_in, !flush_in, and the target's full flag is low. Exactly one of rs_issue_valid/lsb_issue_valid is high, and the entry leaves at the edge. If the head's target is full, the head blocks and younger entries wait (strict order).
- **Payload outputs.** Combinational from the head entry. They are 0 when count==0.
- **Wakeup of stored entries.** At every enabled edge, for each valid entry and each operand with dep≠0:
  - if alu_result_ready && alu_result_rob_index==dep, then val←alu_result_val and dep←0;
  - else if lsb_result_ready && lsb_result_rob_index==dep, then val←lsb_result_val and dep←0.
  - ALU takes priority if both match.
- **Wakeup of the pushing entry.** The same snoop applies to the incoming operands before they are stored.
- **Wakeup on the dispatch path.** out_rsN_val/out_rsN_dep apply the same forward combinationally to the head. An operand broadcast in the dispatch cycle therefore arrives resolved.
- **Flush.** At the edge with flush_in=1: count, head and tail go to 0, no push, no pop. Issue valids are forced low in that cycle. flush_in takes priority over rdy_in=0.
- **rdy_in=0.** Pointers, count and entries are held; no snoop updates; issue valids low; in_ready still reflects count.

## Timing
- **Reset.** After the reset edge: count=0, pointers=0, rs_issue_valid=lsb_issue_valid=0, all payload outputs 0. in_ready=0 while rst_in is high and 1 after.
- **Latency.** An entry pushed at edge N can dispatch in cycle N+1 at the earliest, popping at edge N+1. There is no combinational input→output bypass.
- **Throughput.** One push and one pop per cycle sustained.
- **Simultaneous push and pop.** With 0<count<DEPTH, count is unchanged.
- **Reset mid-operation.** Discards all entries; the same behaviour as flush.
- **Stored state.** The entry count and entries are registers. The only combinational outputs are in_ready, the issue valids and the forwarded payload.

## Test plan
- **Fill and drain.** Push 5 RS ops (pc 0x0,0x4,…,0x10) with DEPTH=4 and rs_full=1. Required: in_ready drops after the 4th. Then release rs_full: dispatch pcs 0x0–0xC in order on 4 consecutive cycles, then in_ready returns to 1.
- **Head-of-line block.** Queue is [LSB op pc 0x20, RS op pc 0x24] with lsb_full=1 and rs_full=0. Required: no issue valid for 3 cycles. Then lsb_full=0: lsb_issue_valid with out_pc=0x20, then rs_issue_valid with out_pc=0x24.
- **Stored wakeup.** Entry with rs1_dep=3 sits blocked. Drive alu_result_ready=1, index 3, val 0xDEADBEEF. Required: on dispatch, out_rs1_val=0xDEADBEEF and out_rs1_dep=0.
- **Dispatch-cycle forward.** The head has rs2_dep=5. In the same cycle as dispatch, lsb_result_ready=1, index 5, val 0x1234. Required: out_rs2_val=0x1234 and out_rs2_dep=0 that cycle.
- **Flush and push collision.** 3 entries stored, flush_in=1 with in_valid=1 and rs_full=0. Required: no issue valid that cycle, count=0 afterwards, and the incoming instruction is dropped.
- **Wrap-around and freeze.** Run 10 push/pop pairs so the pointers wrap; required: order is preserved. Hold rdy_in=0 for 2 cycles with a pending ALU broadcast; required: state is unchanged and no valids are asserted.
